// File: rtl/chip8_countdown_timers.sv
// CHIP-8 delay and sound timers: two 8-bit down-counters stepped by the 60 Hz tick,
// plus a square-wave buzzer generator that runs while the sound timer is nonzero.
module chip8_countdown_timers #(
  parameter int CLOCK_SPEED = 100000,
  parameter int TONE_HZ     = 440,
  parameter int TONE_DIV    = CLOCK_SPEED / (2 * TONE_HZ)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_60hz,
  input  logic       dt_we,
  input  logic       st_we,
  input  logic [7:0] wr_data,
  output logic [7:0] dt_value,
  output logic [7:0] st_value,
  output logic       sound_active,
  output logic       dt_expired,
  output logic       buzzer
);

  localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [TONE_W-1:0] TONE_MAX = TONE_W'(TONE_DIV - 1);

  logic [7:0]        dt_q, dt_d;
  logic [7:0]        st_q, st_d;
  logic              dt_expired_q, dt_expired_d;
  logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
  logic              buzzer_q, buzzer_d;

  // A write always wins over a coincident tick; counters saturate at zero.
  always_comb begin
    dt_d         = dt_q;
    st_d         = st_q;
    dt_expired_d = 1'b0;
    if (dt_we) begin
      dt_d = wr_data;
    end else if (tick_60hz && (dt_q != 8'd0)) begin
      dt_d         = dt_q - 8'd1;
      dt_expired_d = (dt_q == 8'd1);
    end
    if (st_we) begin
      st_d = wr_data;
    end else if (tick_60hz && (st_q != 8'd0)) begin
      st_d = st_q - 8'd1;
    end
  end

  // Tone phase follows the registered ST, so a reload while sounding keeps the phase
  // and a stop clears the buzzer one edge after ST reaches zero.
  always_comb begin
    tone_cnt_d = tone_cnt_q;
    buzzer_d   = buzzer_q;
    if (st_q == 8'd0) begin
      tone_cnt_d = '0;
      buzzer_d   = 1'b0;
    end else if (tone_cnt_q == TONE_MAX) begin
      tone_cnt_d = '0;
      buzzer_d   = ~buzzer_q;
    end else begin
      tone_cnt_d = tone_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dt_q         <= 8'd0;
      st_q         <= 8'd0;
      dt_expired_q <= 1'b0;
      tone_cnt_q   <= '0;
      buzzer_q     <= 1'b0;
    end else begin
      dt_q         <= dt_d;
      st_q         <= st_d;
      dt_expired_q <= dt_expired_d;
      tone_cnt_q   <= tone_cnt_d;
      buzzer_q     <= buzzer_d;
    end
  end

  assign dt_value     = dt_q;
  assign st_value     = st_q;
  assign sound_active = (st_q != 8'd0);
  assign dt_expired   = dt_expired_q;
  assign buzzer       = buzzer_q;

endmodule

// File: tb/tb_chip8_countdown_timers.sv
// Bench for chip8_countdown_timers: a cycle model queues expected outputs as each
// stimulus cycle is driven; they are popped and compared after the clock edge.
module tb_chip8_countdown_timers;

  localparam int CLK_HZ   = 100000;
  localparam int TONE     = 440;
  localparam int TDIV     = CLK_HZ / (2 * TONE);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_60hz = 1'b0;
  logic       dt_we = 1'b0;
  logic       st_we = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic [7:0] dt_value, st_value;
  logic       sound_active, dt_expired, buzzer;

  chip8_countdown_timers #(.CLOCK_SPEED(CLK_HZ), .TONE_HZ(TONE)) dut (
    .clk(clk), .rst_n(rst_n), .tick_60hz(tick_60hz), .dt_we(dt_we), .st_we(st_we),
    .wr_data(wr_data), .dt_value(dt_value), .st_value(st_value),
    .sound_active(sound_active), .dt_expired(dt_expired), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dt;
    int st;
    int snd;
    int exp;
    int buz;
  } exp_t;

  exp_t sb_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state (reflects register contents after the last edge)
  int m_dt = 0, m_st = 0, m_cnt = 0, m_buz = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    vectors++;
    if (obs != expv) begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_dt = 0; m_st = 0; m_cnt = 0; m_buz = 0;
  endtask

  task automatic step(input bit tk, input bit dwe, input bit swe, input int data);
    exp_t e;
    int nd, ns, nc, nb, ne;
    @(negedge clk);
    tick_60hz = tk; dt_we = dwe; st_we = swe; wr_data = data[7:0];
    ne = (!dwe && tk && m_dt == 1) ? 1 : 0;
    if (dwe) nd = data;
    else if (tk && m_dt > 0) nd = m_dt - 1;
    else nd = m_dt;
    if (swe) ns = data;
    else if (tk && m_st > 0) ns = m_st - 1;
    else ns = m_st;
    if (m_st == 0) begin
      nc = 0; nb = 0;
    end else if (m_cnt + 1 == TDIV) begin
      nc = 0; nb = 1 - m_buz;
    end else begin
      nc = m_cnt + 1; nb = m_buz;
    end
    m_dt = nd; m_st = ns; m_cnt = nc; m_buz = nb;
    e.dt = nd; e.st = ns; e.snd = (ns != 0) ? 1 : 0; e.exp = ne; e.buz = nb;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    tick_60hz = 1'b0; dt_we = 1'b0; st_we = 1'b0;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk("dt_value", int'(dt_value), e.dt);
      chk("st_value", int'(st_value), e.st);
      chk("sound_active", int'(sound_active), e.snd);
      chk("dt_expired", int'(dt_expired), e.exp);
      chk("buzzer", int'(buzzer), e.buz);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dt"}, int'(dt_value), 0);
    chk({tag, "_st"}, int'(st_value), 0);
    chk({tag, "_snd"}, int'(sound_active), 0);
    chk({tag, "_exp"}, int'(dt_expired), 0);
    chk({tag, "_buz"}, int'(buzzer), 0);
  endtask

  int buz_seen;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(2);
    chk_all_zero("post_reset");

    // Load DT=3 and count down past zero
    step(1'b0, 1'b1, 1'b0, 3);
    chk("t1_load3", int'(dt_value), 3);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 0);
    chk("t1_no_wrap", int'(dt_value), 0);
    idle(2);

    // Write beats a coincident tick
    step(1'b0, 1'b1, 1'b0, 5);
    step(1'b1, 1'b1, 1'b0, 16);
    chk("t2_write_wins", int'(dt_value), 16);
    idle(1);

    // Sound start, tone phase, stop by ticks
    step(1'b0, 1'b0, 1'b1, 2);
    idle(TDIV - 1);
    chk("t3_silent_before_tdiv", int'(buzzer), 0);
    idle(1);
    chk("t3_first_toggle", int'(buzzer), 1);
    idle(2 * TDIV + 20);
    step(1'b1, 1'b0, 1'b0, 0);
    idle(30);
    step(1'b0, 1'b0, 1'b1, 7);
    idle(40);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 0);
    chk("t3_snd_off", int'(sound_active), 0);
    idle(3);

    // Both timers from 0xFF, no wrap after 255 ticks
    step(1'b0, 1'b1, 1'b1, 255);
    for (int i = 0; i < 256; i++) step(1'b1, 1'b0, 1'b0, 0);
    chk("t4_dt_zero", int'(dt_value), 0);
    chk("t4_st_zero", int'(st_value), 0);
    idle(2);

    // Asynchronous reset mid-countdown
    step(1'b0, 1'b1, 1'b1, 40);
    idle(20);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_async");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("t5_held");
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Sound stop by writing zero
    step(1'b0, 1'b0, 1'b1, 5);
    buz_seen = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'b0, 1'b0, 0);
      if (buzzer) buz_seen = 1;
    end
    chk("t6_buzzer_ran", buz_seen, 1);
    step(1'b0, 1'b0, 1'b1, 0);
    chk("t6_st_zero", int'(st_value), 0);
    chk("t6_buz_lags", int'(buzzer), 1);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("t6_buz_off", int'(buzzer), 0);
    idle(2 * TDIV);
    chk("t6_stays_off", int'(buzzer), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
